// File: rtl/cpu_pkg.sv
// Shared ISA constants, state encoding and instruction classes for the CPU controller.
package cpu_pkg;

  // FSM state encoding
  localparam logic [2:0] WAIT      = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] WRITE_IMM = 3'd2;
  localparam logic [2:0] GET_A     = 3'd3;
  localparam logic [2:0] GET_B     = 3'd4;
  localparam logic [2:0] COMPUTE   = 3'd5;
  localparam logic [2:0] WRITE_REG = 3'd6;
  localparam logic [2:0] HALT      = 3'd7;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // IR field bit positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 11;
  localparam int RN_MSB  = 10;
  localparam int RN_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 5;
  localparam int SH_MSB  = 4;
  localparam int SH_LSB  = 3;
  localparam int RM_MSB  = 2;
  localparam int RM_LSB  = 0;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ALU,
    CLS_CMP,
    CLS_MVN
  } instr_cls_t;

endpackage

// File: rtl/cpu_if.sv
// Instruction/handshake and datapath control bundle between system, controller and datapath.
// CPU_ILLEGAL_TRAP_EN adds the sticky illegal-opcode flag.
interface cpu_if;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] datapath_in;
`ifdef CPU_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  modport master (
    input  in, load, s,
    output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, datapath_in
`ifdef CPU_ILLEGAL_TRAP_EN
   ,output illegal
`endif
  );

  modport slave (
    output in, load, s,
    input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, datapath_in
`ifdef CPU_ILLEGAL_TRAP_EN
   ,input  illegal
`endif
  );
endinterface

// File: rtl/cpu_decoder.sv
// Combinational instruction decoder: splits the IR into fields, immediates and an instruction class.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output instr_cls_t  cls
);

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign op     = ir[OP_MSB:OP_LSB];
  assign rn     = ir[RN_MSB:RN_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rm     = ir[RM_MSB:RM_LSB];
  assign sh     = ir[SH_MSB:SH_LSB];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  always_comb begin
    cls = CLS_NOP;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
      else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  cls = CLS_ALU;
        OP_CMP:  cls = CLS_CMP;
        OP_AND:  cls = CLS_ALU;
        default: cls = CLS_MVN;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore control FSM driving the CPU datapath.
// CPU_ILLEGAL_TRAP_EN: unsupported encodings trap into HALT and raise illegal.
//
// state     | meaning
// WAIT      | idle, w=1, IR loadable
// DECODE    | classify IR, no controls
// WRITE_IMM | write sign-extended imm8 to Rn
// GET_A     | read Rn into A
// GET_B     | read Rm into B
// COMPUTE   | ALU op into C, or status only for CMP
// WRITE_REG | write C to Rd
// HALT      | trapped on illegal encoding, exit by reset only
module cpu_controller
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  cpu_if.master   bus
);

  logic [2:0]  state, state_nx;
  logic [15:0] ir;
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, sh;
  logic [15:0] sximm8, sximm5;
  instr_cls_t  cls;

  cpu_decoder u_dec (
    .ir(ir), .opcode(opcode), .op(op), .rn(rn), .rd(rd), .rm(rm),
    .sh(sh), .sximm8(sximm8), .sximm5(sximm5), .cls(cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == WAIT && bus.load) ir <= bus.in;
    end
  end

  always_comb begin
    state_nx = WAIT;
    case (state)
      WAIT:      state_nx = bus.s ? DECODE : WAIT;
      DECODE: begin
        case (cls)
          CLS_MOV_IMM:          state_nx = WRITE_IMM;
          CLS_MOV_REG, CLS_MVN: state_nx = GET_B;
          CLS_ALU, CLS_CMP:     state_nx = GET_A;
`ifdef CPU_ILLEGAL_TRAP_EN
          default:              state_nx = HALT;
`else
          default:              state_nx = WAIT;
`endif
        endcase
      end
      GET_A:     state_nx = GET_B;
      GET_B:     state_nx = COMPUTE;
      COMPUTE:   state_nx = (cls == CLS_CMP) ? WAIT : WRITE_REG;
`ifdef CPU_ILLEGAL_TRAP_EN
      HALT:      state_nx = HALT;
`endif
      default:   state_nx = WAIT;
    endcase
  end

  always_comb begin
    bus.w           = (state == WAIT);
    bus.readnum     = '0;
    bus.writenum    = '0;
    bus.write       = 1'b0;
    bus.vsel        = 1'b0;
    bus.loada       = 1'b0;
    bus.loadb       = 1'b0;
    bus.loadc       = 1'b0;
    bus.loads       = 1'b0;
    bus.asel        = 1'b0;
    bus.bsel        = 1'b0;
    bus.shift       = SH_NONE;
    bus.ALUop       = ALU_ADD;
    bus.datapath_in = (state == WRITE_IMM) ? sximm8 : sximm5;
    case (state)
      WRITE_IMM: begin
        bus.writenum = rn;
        bus.vsel     = 1'b1;
        bus.write    = 1'b1;
      end
      GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
      end
      GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
      end
      COMPUTE: begin
        bus.shift = sh;
        // MOV reg passes B through ADD with a zeroed A operand
        bus.ALUop = (opcode == OPC_ALU) ? op : ALU_ADD;
        bus.asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
        bus.loads = (cls == CLS_CMP);
        bus.loadc = (cls != CLS_CMP);
      end
      WRITE_REG: begin
        bus.writenum = rd;
        bus.write    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CPU_ILLEGAL_TRAP_EN
  assign bus.illegal = (state == HALT);
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: expected per-cycle control vectors are queued at issue time.
module tb_cpu_controller;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] dp;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  ctl_t q[$];

  cpu_if bus ();

  cpu_controller dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t obs();
    ctl_t c;
    c.w        = bus.w;
    c.readnum  = bus.readnum;
    c.writenum = bus.writenum;
    c.write    = bus.write;
    c.vsel     = bus.vsel;
    c.loada    = bus.loada;
    c.loadb    = bus.loadb;
    c.loadc    = bus.loadc;
    c.loads    = bus.loads;
    c.asel     = bus.asel;
    c.bsel     = bus.bsel;
    c.shift    = bus.shift;
    c.aluop    = bus.ALUop;
    c.dp       = bus.datapath_in;
    return c;
  endfunction

  // Expected control sequence for one instruction, one entry per edge after s is sampled.
  task automatic push_expected(input logic [15:0] instr);
    ctl_t base, c;
    logic [4:0] key;
    logic       is_cmp, is_unary;
    base    = '0;
    base.dp = {{11{instr[4]}}, instr[4:0]};
    key     = instr[15:11];
    q.push_back(base);
    is_cmp   = (key == 5'b10101);
    is_unary = (key == 5'b11000) || (key == 5'b10111);
    if (key == 5'b11010) begin
      c = base;
      c.writenum = instr[10:8];
      c.vsel = 1'b1;
      c.write = 1'b1;
      c.dp = {{8{instr[7]}}, instr[7:0]};
      q.push_back(c);
    end else if (key == 5'b11000 || key[4:2] == 3'b101) begin
      if (!is_unary) begin
        c = base; c.readnum = instr[10:8]; c.loada = 1'b1;
        q.push_back(c);
      end
      c = base; c.readnum = instr[2:0]; c.loadb = 1'b1;
      q.push_back(c);
      c = base;
      c.shift = instr[4:3];
      c.aluop = (key[4:2] == 3'b101) ? instr[12:11] : 2'b00;
      c.asel  = is_unary;
      c.loads = is_cmp;
      c.loadc = !is_cmp;
      q.push_back(c);
      if (!is_cmp) begin
        c = base; c.writenum = instr[7:5]; c.write = 1'b1;
        q.push_back(c);
      end
    end else begin
`ifdef CPU_ILLEGAL_TRAP_EN
      return;
`endif
    end
    c = base;
    c.w = 1'b1;
    q.push_back(c);
  endtask

  // Issue at a point between edges; glitch_at drives load/s with 0xFFFF mid-instruction,
  // abort_at raises reset after that cycle's comparison.
  task automatic run(input logic [15:0] instr, input string name, input int glitch_at, input int abort_at);
    ctl_t exp;
    int   i;
    bus.in = instr;
    bus.load = 1'b1;
    bus.s = 1'b1;
    push_expected(instr);
    i = 0;
    while (q.size() > 0 && i < 20) begin
      @(posedge clk);
      #1;
      if (i == 0) begin bus.load = 1'b0; bus.s = 1'b0; end
      if (i == glitch_at) begin bus.in = 16'hFFFF; bus.load = 1'b1; bus.s = 1'b1; end
      if (i == glitch_at + 1) begin bus.load = 1'b0; bus.s = 1'b0; end
      @(negedge clk);
      exp = q.pop_front();
      chk($sformatf("%s_c%0d", name, i), obs(), exp);
      if (i == abort_at) begin
        reset = 1'b1;
        q.delete();
      end
      i++;
    end
    if (q.size() != 0) begin
      chk($sformatf("%s_timeout", name), 35'(q.size()), 35'd0);
      q.delete();
    end
  endtask

  ctl_t idle;

  initial begin
    reset = 1'b1;
    bus.in = 16'h0000;
    bus.load = 1'b0;
    bus.s = 1'b0;
    idle = '0;
    idle.w = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", obs(), idle);
`ifdef CPU_ILLEGAL_TRAP_EN
    chk("reset_illegal", 35'(bus.illegal), 35'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    run(16'hD007, "mov_imm7", -1, -1);
    run(16'hD1FE, "mov_imm_neg", -1, -1);
    run(16'hA148, "add", -1, -1);
    run(16'hA800, "cmp", -1, -1);
    run(16'hC06D, "mov_reg", -1, -1);
    run(16'hB8FA, "mvn", -1, -1);
    run(16'hB426, "and", -1, -1);
    run(16'hA148, "add_glitch", 1, -1);

    repeat (2) begin
      @(negedge clk);
      chk("idle_hold_w", 35'(bus.w), 35'd1);
    end

    // Abort an ADD in COMPUTE: no WRITE_REG and IR cleared.
    run(16'hA148, "add_abort", -1, 3);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_state", obs(), idle);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort_nowrite_%0d", k), 35'(bus.write), 35'd0);
    end

    run(16'h0000, "nop", -1, -1);
`ifdef CPU_ILLEGAL_TRAP_EN
    bus.in = 16'hD007;
    bus.load = 1'b1;
    bus.s = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("halt_ctl_%0d", k), obs(), 35'd0);
      chk($sformatf("halt_illegal_%0d", k), 35'(bus.illegal), 35'd1);
    end
    bus.load = 1'b0;
    bus.s = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("halt_reset_state", obs(), idle);
    chk("halt_reset_illegal", 35'(bus.illegal), 35'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
